// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game-sequencing controller.
package pong_pkg;

  // Game flow states, encoded 0..3.
  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_t;

  // Winner codes shown on the game-over overlay.
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // Width of one BCD score digit.
  localparam int DIGIT_W = 4;

  // Decimal value after one saturating increment of a 0..99 score.
  function automatic logic [6:0] sat_inc(input logic [6:0] value);
    if (value >= 7'd99) begin
      return 7'd99;
    end else begin
      return value + 7'd1;
    end
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Game-controller signal bundle: frame/button/miss events in, score and
// overlay controls out. master = controller, slave = surrounding system.
interface pong_game_ctrl_if;
  import pong_pkg::*;

  logic               refr_tick;
  logic [3:0]         btn;
  logic               p1_miss;
  logic               p2_miss;
  logic [DIGIT_W-1:0] dig0;
  logic [DIGIT_W-1:0] dig1;
  logic [DIGIT_W-1:0] dig2;
  logic [DIGIT_W-1:0] dig3;
  logic [1:0]         ball;
  logic               graph_still;
  logic               ball_reset;
  logic               show_rule;
  logic               show_logo;
  logic               show_over;
  logic [1:0]         winner;

  modport master (
    input  refr_tick, btn, p1_miss, p2_miss,
    output dig0, dig1, dig2, dig3, ball, graph_still, ball_reset,
           show_rule, show_logo, show_over, winner
  );

  modport slave (
    output refr_tick, btn, p1_miss, p2_miss,
    input  dig0, dig1, dig2, dig3, ball, graph_still, ball_reset,
           show_rule, show_logo, show_over, winner
  );

endinterface

// File: rtl/bcd2_counter.sv
// Two-digit BCD score counter, saturating at 99, with binary value readout.
module bcd2_counter
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] ones,
  output logic [DIGIT_W-1:0] tens,
  output logic [6:0]         value_bin
);

  // Clear has priority over increment; 99 holds instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (clr) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (inc) begin
      if (ones == 4'd9) begin
        if (tens != 4'd9) begin
          ones <= 4'd0;
          tens <= tens + 4'd1;
        end
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

  assign value_bin = 7'(tens) * 7'd10 + 7'(ones);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: new-game / play / new-ball / game-over flow,
// per-player BCD scores, ball count, pause timer and overlay enables.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALLS_INIT  = 3,
  parameter int WIN_SCORE   = 11,
  parameter int TIMER_TICKS = 120
) (
  input  logic             clk,
  input  logic             reset_n,
  pong_game_ctrl_if.master bus
);

  localparam logic [1:0] BALL_VAL  = 2'(BALLS_INIT);
  localparam logic [6:0] WIN_VAL   = 7'(WIN_SCORE);
  localparam logic [6:0] TIMER_VAL = 7'(TIMER_TICKS);

  state_t     state;
  logic [6:0] timer;
  logic [1:0] ball;
  logic [1:0] winner;
  logic       ball_reset;

  logic       start;
  logic       timer_up;
  logic       miss_any;
  logic       clr;
  logic       p1_inc;
  logic       p2_inc;
  logic [6:0] p1_bin;
  logic [6:0] p2_bin;
  logic [6:0] p1_next;
  logic [6:0] p2_next;
  logic [1:0] ball_dec;
  logic       game_end;
  logic [1:0] win_code;

  logic [DIGIT_W-1:0] p1_ones, p1_tens, p2_ones, p2_tens;

  // Event decode and end-of-game check on the scores as they will be after this cycle.
  always_comb begin
    start    = |bus.btn;
    timer_up = (timer == 7'd0);
    miss_any = bus.p1_miss | bus.p2_miss;
    clr      = (state == NEWGAME) && start;
    // A simultaneous double miss scores for nobody.
    p1_inc   = (state == PLAY) && bus.p2_miss && !bus.p1_miss;
    p2_inc   = (state == PLAY) && bus.p1_miss && !bus.p2_miss;
    p1_next  = p1_inc ? sat_inc(p1_bin) : p1_bin;
    p2_next  = p2_inc ? sat_inc(p2_bin) : p2_bin;
    ball_dec = ball - 2'd1;
    game_end = (p1_next == WIN_VAL) || (p2_next == WIN_VAL) || (ball_dec == 2'd0);
    if (p1_next > p2_next) begin
      win_code = WIN_P1;
    end else if (p2_next > p1_next) begin
      win_code = WIN_P2;
    end else begin
      win_code = WIN_TIE;
    end
  end

  bcd2_counter u_p1_score (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .inc       (p1_inc),
    .ones      (p1_ones),
    .tens      (p1_tens),
    .value_bin (p1_bin)
  );

  bcd2_counter u_p2_score (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .inc       (p2_inc),
    .ones      (p2_ones),
    .tens      (p2_tens),
    .value_bin (p2_bin)
  );

  // Game flow FSM with pause timer, ball count, winner and recentre pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= NEWGAME;
      timer      <= 7'd0;
      ball       <= BALL_VAL;
      winner     <= WIN_NONE;
      ball_reset <= 1'b0;
    end else begin
      ball_reset <= 1'b0;
      if (bus.refr_tick && !timer_up) begin
        timer <= timer - 7'd1;
      end
      case (state)
        NEWGAME: begin
          if (start) begin
            ball       <= BALL_VAL;
            winner     <= WIN_NONE;
            ball_reset <= 1'b1;
            state      <= PLAY;
          end
        end
        PLAY: begin
          if (miss_any) begin
            ball  <= ball_dec;
            timer <= TIMER_VAL;
            if (game_end) begin
              winner <= win_code;
              state  <= OVER;
            end else begin
              state  <= NEWBALL;
            end
          end
        end
        NEWBALL: begin
          // A button already held is taken on the first timer_up cycle.
          if (timer_up && start) begin
            ball_reset <= 1'b1;
            state      <= PLAY;
          end
        end
        OVER: begin
          if (timer_up) begin
            state <= NEWGAME;
          end
        end
        default: begin
          state <= NEWGAME;
        end
      endcase
    end
  end

  assign bus.dig0        = p1_ones;
  assign bus.dig1        = p1_tens;
  assign bus.dig2        = p2_ones;
  assign bus.dig3        = p2_tens;
  assign bus.ball        = ball;
  assign bus.winner      = winner;
  assign bus.ball_reset  = ball_reset;
  assign bus.graph_still = (state != PLAY);
  assign bus.show_rule   = (state == NEWGAME);
  assign bus.show_logo   = (state == NEWGAME);
  assign bus.show_over   = (state == OVER);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed scoreboard bench for pong_game_ctrl and its BCD score counter.
module tb_pong_game_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  logic tick;

  always #5 clk = ~clk;

  pong_game_ctrl_if if_a ();
  pong_game_ctrl_if if_b ();

  assign if_a.refr_tick = tick;
  assign if_b.refr_tick = tick;

  pong_game_ctrl #(.BALLS_INIT(3), .WIN_SCORE(11), .TIMER_TICKS(120)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_a)
  );

  pong_game_ctrl #(.BALLS_INIT(3), .WIN_SCORE(2), .TIMER_TICKS(2)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_b)
  );

  logic       c_clr;
  logic       c_inc;
  logic [3:0] c_ones;
  logic [3:0] c_tens;
  logic [6:0] c_bin;

  bcd2_counter u_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (c_clr),
    .inc       (c_inc),
    .ones      (c_ones),
    .tens      (c_tens),
    .value_bin (c_bin)
  );

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  function automatic logic [7:0] observe(string tag);
    case (tag)
      "a_dig0":       return 8'(if_a.dig0);
      "a_dig1":       return 8'(if_a.dig1);
      "a_dig2":       return 8'(if_a.dig2);
      "a_dig3":       return 8'(if_a.dig3);
      "a_ball":       return 8'(if_a.ball);
      "a_winner":     return 8'(if_a.winner);
      "a_ball_reset": return 8'(if_a.ball_reset);
      "a_still":      return 8'(if_a.graph_still);
      "a_rule":       return 8'(if_a.show_rule);
      "a_logo":       return 8'(if_a.show_logo);
      "a_over":       return 8'(if_a.show_over);
      "b_dig0":       return 8'(if_b.dig0);
      "b_ball":       return 8'(if_b.ball);
      "b_winner":     return 8'(if_b.winner);
      "b_still":      return 8'(if_b.graph_still);
      "b_over":       return 8'(if_b.show_over);
      "c_ones":       return 8'(c_ones);
      "c_tens":       return 8'(c_tens);
      "c_bin":        return 8'(c_bin);
      default:        return 8'hxx;
    endcase
  endfunction

  task automatic exp_push(input string tag, input logic [7:0] value);
    exp_t e;
    e.tag = tag;
    e.exp = value;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    while (sb.size() > 0) begin
      exp_t e;
      logic [7:0] o;
      e = sb.pop_front();
      o = observe(e.tag);
      n_checks++;
      assert (o === e.exp) else begin
        n_fails++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    check_sb();
  endtask

  // Ends #1 after the edge that samples the last tick.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      if (i != n - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // NEWBALL pause on dut_a with btn already held: exit exactly one edge after tick 120.
  task automatic pause_and_resume_a();
    ticks(119);
    exp_push("a_still", 8'd1);
    check_sb();
    ticks(1);
    exp_push("a_still", 8'd1);
    exp_push("a_ball_reset", 8'd0);
    check_sb();
    exp_push("a_still", 8'd0);
    exp_push("a_ball_reset", 8'd1);
    step(1);
    if_a.btn = 4'b0000;
    exp_push("a_ball_reset", 8'd0);
    exp_push("a_still", 8'd0);
    step(1);
  endtask

  initial begin
    reset_n = 1'b0;
    tick = 1'b0;
    if_a.btn = 4'b0000; if_a.p1_miss = 1'b0; if_a.p2_miss = 1'b0;
    if_b.btn = 4'b0000; if_b.p1_miss = 1'b0; if_b.p2_miss = 1'b0;
    c_clr = 1'b0; c_inc = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    exp_push("a_dig0", 8'd0); exp_push("a_dig1", 8'd0);
    exp_push("a_dig2", 8'd0); exp_push("a_dig3", 8'd0);
    exp_push("a_ball", 8'd3); exp_push("a_winner", 8'd0);
    exp_push("a_ball_reset", 8'd0); exp_push("a_still", 8'd1);
    exp_push("a_rule", 8'd1); exp_push("a_logo", 8'd1); exp_push("a_over", 8'd0);
    check_sb();
    reset_n = 1'b1;
    step(1);

    // Start press
    if_a.btn = 4'b0001;
    exp_push("a_ball_reset", 8'd1); exp_push("a_still", 8'd0);
    exp_push("a_rule", 8'd0); exp_push("a_logo", 8'd0); exp_push("a_over", 8'd0);
    exp_push("a_ball", 8'd3);
    step(1);
    if_a.btn = 4'b0000;
    exp_push("a_ball_reset", 8'd0); exp_push("a_still", 8'd0);
    step(1);

    // P2 misses, P1 scores; button held through the pause
    if_a.p2_miss = 1'b1;
    if_a.btn = 4'b0010;
    exp_push("a_dig0", 8'd1); exp_push("a_dig1", 8'd0); exp_push("a_dig2", 8'd0);
    exp_push("a_ball", 8'd2); exp_push("a_still", 8'd1);
    exp_push("a_rule", 8'd0); exp_push("a_over", 8'd0);
    step(1);
    if_a.p2_miss = 1'b0;
    pause_and_resume_a();

    // P1 misses, P2 scores
    if_a.p1_miss = 1'b1;
    if_a.btn = 4'b1000;
    exp_push("a_dig2", 8'd1); exp_push("a_dig0", 8'd1);
    exp_push("a_ball", 8'd1); exp_push("a_still", 8'd1); exp_push("a_over", 8'd0);
    step(1);
    if_a.p1_miss = 1'b0;
    pause_and_resume_a();

    // Simultaneous misses on the last ball: tie game over
    if_a.p1_miss = 1'b1;
    if_a.p2_miss = 1'b1;
    exp_push("a_dig0", 8'd1); exp_push("a_dig2", 8'd1); exp_push("a_ball", 8'd0);
    exp_push("a_over", 8'd1); exp_push("a_still", 8'd1);
    exp_push("a_winner", 8'd3); exp_push("a_rule", 8'd0);
    step(1);
    if_a.p1_miss = 1'b0;
    if_a.p2_miss = 1'b0;

    // Misses ignored in OVER
    if_a.p2_miss = 1'b1;
    exp_push("a_dig0", 8'd1); exp_push("a_over", 8'd1);
    step(1);
    if_a.p2_miss = 1'b0;
    if_a.p1_miss = 1'b1;
    exp_push("a_dig2", 8'd1); exp_push("a_ball", 8'd0);
    step(1);
    if_a.p1_miss = 1'b0;

    // Over timeout back to NEWGAME with scores kept
    ticks(119);
    exp_push("a_over", 8'd1);
    check_sb();
    ticks(1);
    exp_push("a_over", 8'd1);
    check_sb();
    exp_push("a_over", 8'd0); exp_push("a_rule", 8'd1); exp_push("a_logo", 8'd1);
    exp_push("a_still", 8'd1); exp_push("a_dig0", 8'd1); exp_push("a_dig2", 8'd1);
    exp_push("a_winner", 8'd3); exp_push("a_ball", 8'd0);
    step(1);
    if_a.btn = 4'b0100;
    exp_push("a_dig0", 8'd0); exp_push("a_dig2", 8'd0); exp_push("a_ball", 8'd3);
    exp_push("a_winner", 8'd0); exp_push("a_ball_reset", 8'd1); exp_push("a_still", 8'd0);
    step(1);
    if_a.btn = 4'b0000;
    step(1);

    // Win by score with balls left (WIN_SCORE=2, TIMER_TICKS=2)
    if_b.btn = 4'b0001;
    exp_push("b_still", 8'd0);
    step(1);
    if_b.btn = 4'b0000;
    if_b.p2_miss = 1'b1;
    exp_push("b_dig0", 8'd1); exp_push("b_ball", 8'd2);
    exp_push("b_still", 8'd1); exp_push("b_over", 8'd0);
    step(1);
    if_b.p2_miss = 1'b0;
    ticks(2);
    exp_push("b_still", 8'd1);
    check_sb();
    if_b.btn = 4'b0001;
    exp_push("b_still", 8'd0);
    step(1);
    if_b.btn = 4'b0000;
    if_b.p2_miss = 1'b1;
    exp_push("b_dig0", 8'd2); exp_push("b_ball", 8'd1);
    exp_push("b_over", 8'd1); exp_push("b_winner", 8'd1);
    step(1);
    if_b.p2_miss = 1'b0;

    // BCD carry and saturation
    c_clr = 1'b1;
    exp_push("c_bin", 8'd0);
    step(1);
    c_clr = 1'b0;
    c_inc = 1'b1;
    exp_push("c_ones", 8'd9); exp_push("c_tens", 8'd0); exp_push("c_bin", 8'd9);
    step(9);
    exp_push("c_ones", 8'd0); exp_push("c_tens", 8'd1); exp_push("c_bin", 8'd10);
    step(1);
    exp_push("c_ones", 8'd9); exp_push("c_tens", 8'd9); exp_push("c_bin", 8'd99);
    step(89);
    exp_push("c_ones", 8'd9); exp_push("c_tens", 8'd9); exp_push("c_bin", 8'd99);
    step(1);
    c_inc = 1'b0;

    // Asynchronous reset mid-PLAY with P1 scored
    if_a.p2_miss = 1'b1;
    if_a.btn = 4'b0001;
    exp_push("a_dig0", 8'd1);
    step(1);
    if_a.p2_miss = 1'b0;
    pause_and_resume_a();
    #3;
    reset_n = 1'b0;
    #1;
    exp_push("a_dig0", 8'd0); exp_push("a_ball", 8'd3); exp_push("a_rule", 8'd1);
    exp_push("a_logo", 8'd1); exp_push("a_still", 8'd1);
    exp_push("a_ball_reset", 8'd0); exp_push("a_winner", 8'd0);
    check_sb();
    exp_push("a_ball_reset", 8'd0); exp_push("a_still", 8'd1);
    step(1);
    reset_n = 1'b1;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
